// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Timed phase sequencer for a 3-road junction. Each road is served as
//   GREEN -> YELLOW -> ALL_RED. The green length of a road is sized from its
//   waiting-vehicle count when that green starts. Roads with a zero count are
//   skipped, and an emergency request preempts service toward the busiest road.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous reset, active low
//   emerg        emergency request (level), sampled every clock
//   traffic1..3  waiting-vehicle counts for road0..road2
//   red          red lamp per road (bit i = road i)
//   green        green lamp per road
//   yellow       yellow lamp per road
//   active_road  road in GREEN/YELLOW; holds its last value during ALL_RED
//   phase        00 GREEN, 01 YELLOW, 10 ALL_RED
//   out          count of active_road in GREEN/YELLOW, 0 in ALL_RED
module traffic_phase_scheduler #(
  parameter int unsigned W         = 16,
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 32,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned EXT_SHIFT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         emerg,
  input  logic [W-1:0] traffic1,
  input  logic [W-1:0] traffic2,
  input  logic [W-1:0] traffic3,
  output logic [2:0]   red,
  output logic [2:0]   green,
  output logic [2:0]   yellow,
  output logic [1:0]   active_road,
  output logic [1:0]   phase,
  output logic [W-1:0] out
);

  localparam int unsigned TW  = $clog2(MAX_GREEN + 1);
  localparam int unsigned WP1 = W + 1;

  localparam logic [TW-1:0] YEL_LOAD = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALR_LOAD = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [W:0]    MIN_G    = WP1'(MIN_GREEN);
  localparam logic [W:0]    MAX_G    = WP1'(MAX_GREEN);
  localparam logic [W:0]    W_ONE    = WP1'(1);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_t;

  phase_t        phase_q, phase_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    road_q, road_d;
  logic [1:0]    last_q, last_d;
  logic          pend_q, pend_d;

  logic [W-1:0]  cnt [3];
  logic [1:0]    target;
  logic [1:0]    rr_c0, rr_c1, rr_c2, rr_pick, sel;
  logic [W-1:0]  max01;
  logic          gt10;
  logic [W:0]    ext, gsum, glen, glen_m1;
  logic [TW-1:0] green_load;

  function automatic logic [1:0] inc_road(input logic [1:0] r);
    return (r == 2'd2) ? 2'd0 : r + 2'd1;
  endfunction

  always_comb begin
    cnt[0] = traffic1;
    cnt[1] = traffic2;
    cnt[2] = traffic3;
  end

  // Busiest road; strict compares keep ties on the lowest index.
  always_comb begin
    gt10   = cnt[1] > cnt[0];
    max01  = gt10 ? cnt[1] : cnt[0];
    target = (cnt[2] > max01) ? 2'd2 : (gt10 ? 2'd1 : 2'd0);
  end

  // Round-robin candidates after last_served; the served road itself is last.
  always_comb begin
    rr_c0 = inc_road(last_q);
    rr_c1 = inc_road(rr_c0);
    rr_c2 = last_q;
    if (cnt[rr_c0] != '0)      rr_pick = rr_c0;
    else if (cnt[rr_c1] != '0) rr_pick = rr_c1;
    else if (cnt[rr_c2] != '0) rr_pick = rr_c2;
    else                       rr_pick = rr_c0;
    sel = (pend_q | emerg) ? target : rr_pick;
  end

  // Green length of the selected road, computed one bit wider than the counts.
  always_comb begin
    ext        = {1'b0, cnt[sel]} >> EXT_SHIFT;
    gsum       = MIN_G + ext;
    glen       = (gsum > MAX_G) ? MAX_G : gsum;
    glen_m1    = glen - W_ONE;
    green_load = glen_m1[TW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_ALLRED;
      timer_q <= ALR_LOAD;
      road_q  <= 2'd0;
      last_q  <= 2'd2;
      pend_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      timer_q <= timer_d;
      road_q  <= road_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    timer_d = timer_q;
    road_d  = road_q;
    last_d  = last_q;
    pend_d  = pend_q;
    unique case (phase_q)
      PH_GREEN: begin
        if (emerg && (road_q != target)) begin
          // Abort this green in favour of the busiest road.
          phase_d = PH_YELLOW;
          timer_d = YEL_LOAD;
          pend_d  = 1'b1;
        end else if (emerg) begin
          // Busiest road already green: hold, timer frozen.
          timer_d = timer_q;
        end else if (timer_q == '0) begin
          phase_d = PH_YELLOW;
          timer_d = YEL_LOAD;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      PH_YELLOW: begin
        if (emerg) pend_d = 1'b1;
        if (timer_q == '0) begin
          phase_d = PH_ALLRED;
          timer_d = ALR_LOAD;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      PH_ALLRED: begin
        if (emerg) pend_d = 1'b1;
        if (timer_q == '0) begin
          phase_d = PH_GREEN;
          timer_d = green_load;
          road_d  = sel;
          last_d  = sel;
          pend_d  = 1'b0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end
      default: begin
        phase_d = PH_ALLRED;
        timer_d = ALR_LOAD;
      end
    endcase
  end

  always_comb begin
    red    = '1;
    green  = '0;
    yellow = '0;
    unique case (phase_q)
      PH_GREEN: begin
        green[road_q] = 1'b1;
        red[road_q]   = 1'b0;
      end
      PH_YELLOW: begin
        yellow[road_q] = 1'b1;
        red[road_q]    = 1'b0;
      end
      default: ;
    endcase
    out         = (phase_q == PH_ALLRED) ? '0 : cnt[road_q];
    active_road = road_q;
    phase       = phase_q;
  end

endmodule
